multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
// Parametrised multi-cycle control unit for the MIPS datapath. Decodes the OPW-bit opcode
// and sequences each instruction over 3-5+ cycles via an FSM, driving datapath enables
// (regdes, branch, memred, memtoreg, aluop, memwr, alusrc, regwr, jump, irwr, pcwr).
// Adds an instruction-fetch handshake, data-memory wait states with timeout, and a sticky error flag.
// PARAMETERS
// OPW           4   opcode width; decoded opcodes are 0..8, any nonzero bit above [3] = illegal
// MEM_WAIT_MAX  15  max cycles in MEM_RD/MEM_WR waiting for mem_ready before timeout (>=1)
// PORTS
// clk          in   1      rising-edge clock
// reset_n      in   1      asynchronous active-low reset
// instr_valid  in   1      fetched instruction word valid on datapath this cycle
// code         in   OPW    opcode, sampled on the FETCH handshake (irwr) only
// zero         in   1      ALU zero flag, used in BRANCH
// mem_ready    in   1      data memory completed read/write this cycle
// regdes       out  1      1 = rd destination (R-type), 0 = rt
// branch       out  1      branch state active
// memred       out  1      data memory read strobe
// memtoreg     out  1      1 = write-back data from memory
// aluop        out  2      00 add (addr), 01 subtract (compare), 10 R-type op from opcode
// memwr        out  1      data memory write strobe
// alusrc       out  1      1 = ALU B from sign-extended immediate
// regwr        out  1      register file write enable
// jump         out  1      jump state active
// irwr         out  1      instruction register load (= FETCH & instr_valid)
// pcwr         out  1      PC update: irwr | (branch & zero) | jump
// instr_done   out  1      one-cycle pulse in last cycle of each instruction
// err          out  1      sticky: timeout or illegal opcode; cleared only by reset
// state        out  4      current state encoding (debug)
// BEHAVIOUR
// States: RST=0 FETCH=1 DECODE=2 EXEC_R=3 WB_R=4 ADDR=5 MEM_RD=6 WB_MEM=7 MEM_WR=8 BR=9 JMP=10 TRAP=11.
// Reset (async): state<=RST, err<=0, wait counter<=0. RST decodes all outputs 0; RST->FETCH next clk.
// Outputs are Moore decode of state except irwr/pcwr (Mealy on instr_valid, zero).
// FETCH: hold until instr_valid=1; that cycle irwr=pcwr=1, opcode latched, ->DECODE.
// DECODE (all outputs 0): op 0-4 (AND,OR,ADD,SUB,SLT)->EXEC_R; 5 LOAD/6 STORE->ADDR;
//   7 BRANCH->BR; 8 JUMP->JMP; other -> see CONFIGURATION.
// EXEC_R: aluop=10, alusrc=0 ->WB_R.  WB_R: regdes=1, regwr=1, memtoreg=0, done ->FETCH (4 cyc).
// ADDR: aluop=00, alusrc=1; ->MEM_RD if LOAD else MEM_WR.
// MEM_RD: memred=1, alusrc=1 held; on mem_ready ->WB_MEM.  WB_MEM: regdes=0, memtoreg=1, regwr=1,
//   done ->FETCH (5 cycles with zero wait).
// MEM_WR: memwr=1, alusrc=1 held; on mem_ready done ->FETCH (4 cycles zero wait).
// BR: branch=1, aluop=01, alusrc=0; pcwr=zero; done ->FETCH (3 cyc).  JMP: jump=1, pcwr=1, done ->FETCH.
// Wait counter: zeroed on entry to MEM_RD/MEM_WR, +1 per cycle without mem_ready. If mem_ready low
//   in the MEM_WAIT_MAX-th cycle: timeout -> err<=1, done pulse, ->FETCH (no regwr). mem_ready in
//   that final cycle counts as success. mem_ready outside MEM_RD/MEM_WR is ignored.
// instr_valid outside FETCH ignored; code changes after FETCH handshake have no effect.
// memred and memwr never both 1; regwr never 1 outside WB_R/WB_MEM.
// Reset asserted mid-instruction aborts immediately; no partial write-back afterwards.
// CONFIGURATION
// ILLEGAL_TRAP_EN defined: illegal opcode in DECODE -> TRAP; err<=1; TRAP drives all outputs 0
//   (instr_done=0, irwr=0) and is left only by reset.
// ILLEGAL_TRAP_EN undefined: illegal opcode is a NOP: err<=1, instr_done pulses in DECODE, ->FETCH;
//   TRAP state unreachable. Timeout handling identical in both builds.
// TESTING
// 1 reset_n=0 mid-MEM_RD, release -> all outputs 0, state=0 then 1 next clk, err=0.
// 2 code=0010, instr_valid=1 in FETCH -> irwr=pcwr=1; EXEC_R aluop=10; WB_R regdes=regwr=1; done at cyc 4.
// 3 code=0101, mem_ready after 3 wait cycles -> memred=1 for 4 cyc; WB_MEM memtoreg=regwr=1; err=0.
// 4 code=0110, mem_ready never, MEM_WAIT_MAX=15 -> memwr=1 exactly 15 cyc, err=1, back to FETCH, regwr=0.
// 5 code=0111 zero=1 -> pcwr=1 in BR; repeat zero=0 -> pcwr=0; done after 3 cycles each.
// 6 code=1111 -> with ILLEGAL_TRAP_EN: state=11 stuck, err=1; without: done in DECODE, next state=FETCH.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: fetch handshake, decode, per-class sequencing, memory wait states with timeout, sticky err.
// Latency: R-type 4 cycles, load 5+wait, store 4+wait, branch/jump 3. Backpressure: holds in FETCH until instr_valid and in MEM_RD/MEM_WR until mem_ready or timeout.
// Build option ILLEGAL_TRAP_EN: illegal opcode locks the FSM in TRAP until reset; otherwise the opcode retires as a NOP with err set.
module multicycle_control #(
    parameter int OPW          = 4,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           instr_valid,
    input  logic [OPW-1:0] code,
    input  logic           zero,
    input  logic           mem_ready,
    output logic           regdes,
    output logic           branch,
    output logic           memred,
    output logic           memtoreg,
    output logic [1:0]     aluop,
    output logic           memwr,
    output logic           alusrc,
    output logic           regwr,
    output logic           jump,
    output logic           irwr,
    output logic           pcwr,
    output logic           instr_done,
    output logic           err,
    output logic [3:0]     state
);

    typedef enum logic [3:0] {
        S_RST    = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC_R = 4'd3,
        S_WB_R   = 4'd4,
        S_ADDR   = 4'd5,
        S_MEM_RD = 4'd6,
        S_WB_MEM = 4'd7,
        S_MEM_WR = 4'd8,
        S_BR     = 4'd9,
        S_JMP    = 4'd10,
        S_TRAP   = 4'd11
    } state_t;

    localparam int            CW        = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_WAIT_MAX - 1);

    state_t         r_state;
    state_t         w_next;
    logic [OPW-1:0] r_op;
    logic [CW-1:0]  r_wait;
    logic           r_err;
    logic           w_set_err;
    logic           w_mem_st;
    logic           w_timeout;
    logic [31:0]    w_op;

    assign w_op      = 32'(r_op);
    assign w_mem_st  = (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
    // r_wait counts the cycles already spent waiting, so the last allowed cycle sees MEM_WAIT_MAX-1.
    assign w_timeout = w_mem_st && !mem_ready && (r_wait == WAIT_LAST);
    assign err       = r_err;
    assign state     = r_state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_RST;
            r_op    <= '0;
            r_wait  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (irwr) begin
                r_op <= code;
            end
            if (w_mem_st && !mem_ready && !w_timeout) begin
                r_wait <= r_wait + CW'(1);
            end else begin
                r_wait <= '0;
            end
            if (w_set_err) begin
                r_err <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_set_err  = 1'b0;
        regdes     = 1'b0;
        branch     = 1'b0;
        memred     = 1'b0;
        memtoreg   = 1'b0;
        aluop      = 2'b00;
        memwr      = 1'b0;
        alusrc     = 1'b0;
        regwr      = 1'b0;
        jump       = 1'b0;
        irwr       = 1'b0;
        pcwr       = 1'b0;
        instr_done = 1'b0;
        case (r_state)
            S_RST: w_next = S_FETCH;
            S_FETCH: begin
                if (instr_valid) begin
                    irwr   = 1'b1;
                    pcwr   = 1'b1;
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                if (w_op <= 32'd4) begin
                    w_next = S_EXEC_R;
                end else if ((w_op == 32'd5) || (w_op == 32'd6)) begin
                    w_next = S_ADDR;
                end else if (w_op == 32'd7) begin
                    w_next = S_BR;
                end else if (w_op == 32'd8) begin
                    w_next = S_JMP;
                end else begin
                    w_set_err = 1'b1;
`ifdef ILLEGAL_TRAP_EN
                    w_next = S_TRAP;
`else
                    instr_done = 1'b1;
                    w_next     = S_FETCH;
`endif
                end
            end
            S_EXEC_R: begin
                aluop  = 2'b10;
                w_next = S_WB_R;
            end
            S_WB_R: begin
                regdes     = 1'b1;
                regwr      = 1'b1;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
            S_ADDR: begin
                alusrc = 1'b1;
                w_next = (w_op == 32'd5) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                memred = 1'b1;
                alusrc = 1'b1;
                if (mem_ready) begin
                    w_next = S_WB_MEM;
                end else if (w_timeout) begin
                    instr_done = 1'b1;
                    w_set_err  = 1'b1;
                    w_next     = S_FETCH;
                end
            end
            S_WB_MEM: begin
                memtoreg   = 1'b1;
                regwr      = 1'b1;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEM_WR: begin
                memwr  = 1'b1;
                alusrc = 1'b1;
                if (mem_ready || w_timeout) begin
                    instr_done = 1'b1;
                    w_set_err  = w_timeout;
                    w_next     = S_FETCH;
                end
            end
            S_BR: begin
                branch     = 1'b1;
                aluop      = 2'b01;
                pcwr       = zero;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
            S_JMP: begin
                jump       = 1'b1;
                pcwr       = 1'b1;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
`ifdef ILLEGAL_TRAP_EN
            S_TRAP: w_next = S_TRAP;
`else
            S_TRAP: w_next = S_FETCH;
`endif
            default: w_next = S_RST;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction expected cycle tables built from opcode class,
// random fetch gaps, memory latencies, branch flags and ignored-input noise.
module tb_multicycle_control;

    localparam int MAX = 15;

    typedef struct packed {
        logic       regdes;
        logic       branch;
        logic       memred;
        logic       memtoreg;
        logic [1:0] aluop;
        logic       memwr;
        logic       alusrc;
        logic       regwr;
        logic       jump;
        logic       irwr;
        logic       pcwr;
        logic       done;
        logic       err;
        logic [3:0] st;
    } out_t;

    logic       clk;
    logic       reset_n;
    logic       instr_valid;
    logic [3:0] code;
    logic       zero;
    logic       mem_ready;
    logic       regdes, branch, memred, memtoreg, memwr, alusrc, regwr, jump, irwr, pcwr, instr_done, err;
    logic [1:0] aluop;
    logic [3:0] state;
    out_t       obs;

    int   n_checks = 0;
    int   n_fails  = 0;
    logic m_err    = 1'b0;

    multicycle_control #(.OPW(4), .MEM_WAIT_MAX(MAX)) dut (
        .clk(clk), .reset_n(reset_n), .instr_valid(instr_valid), .code(code),
        .zero(zero), .mem_ready(mem_ready), .regdes(regdes), .branch(branch),
        .memred(memred), .memtoreg(memtoreg), .aluop(aluop), .memwr(memwr),
        .alusrc(alusrc), .regwr(regwr), .jump(jump), .irwr(irwr), .pcwr(pcwr),
        .instr_done(instr_done), .err(err), .state(state)
    );

    assign obs = {regdes, branch, memred, memtoreg, aluop, memwr, alusrc, regwr,
                  jump, irwr, pcwr, instr_done, err, state};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [3:0] rnd4();
        return 4'($urandom);
    endfunction

    function automatic out_t base(input logic [3:0] st);
        out_t e;
        e     = '0;
        e.st  = st;
        e.err = m_err;
        return e;
    endfunction

    // Called at posedge+1: drive this cycle's inputs, compare at the falling edge.
    task automatic step(input logic iv, input logic [3:0] cd, input logic mr, input logic zr,
                        input out_t e, input string tag);
        instr_valid = iv;
        code        = cd;
        mem_ready   = mr;
        zero        = zr;
        @(negedge clk);
        check(tag, 32'(obs), 32'(e));
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        m_err   = 1'b0;
        #1;
        check("rst_async", 32'(obs), 32'(base(4'd0)));
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_hold", 32'(obs), 32'(base(4'd0)));
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step(rbit(), rnd4(), rbit(), rbit(), base(4'd0), "rst_release");
    endtask

    // One instruction, starting in FETCH. lat = MEM cycle in which mem_ready rises (outside 1..MAX: never).
    // abort_k != 0 asserts reset at the start of that MEM cycle.
    task automatic run_instr(input logic [3:0] op, input int gap, input int lat,
                             input logic zr, input int abort_k);
        out_t e;
        bit   fin;
        for (int g = 0; g < gap; g++) begin
            step(1'b0, rnd4(), rbit(), rbit(), base(4'd1), "fetch_idle");
        end
        e = base(4'd1); e.irwr = 1'b1; e.pcwr = 1'b1;
        step(1'b1, op, rbit(), rbit(), e, "fetch");
        e = base(4'd2);
        if (op > 4'd8) begin
`ifdef ILLEGAL_TRAP_EN
            step(rbit(), rnd4(), rbit(), rbit(), e, "decode_ill");
            m_err = 1'b1;
            for (int t = 0; t < 4; t++) begin
                step(1'b1, rnd4(), rbit(), rbit(), base(4'd11), "trap_hold");
            end
`else
            e.done = 1'b1;
            step(rbit(), rnd4(), rbit(), rbit(), e, "decode_ill");
            m_err = 1'b1;
`endif
            return;
        end
        step(rbit(), rnd4(), rbit(), rbit(), e, "decode");
        if (op <= 4'd4) begin
            e = base(4'd3); e.aluop = 2'b10;
            step(rbit(), rnd4(), rbit(), rbit(), e, "exec_r");
            e = base(4'd4); e.regdes = 1'b1; e.regwr = 1'b1; e.done = 1'b1;
            step(rbit(), rnd4(), rbit(), rbit(), e, "wb_r");
        end else if (op == 4'd5 || op == 4'd6) begin
            e = base(4'd5); e.alusrc = 1'b1;
            step(rbit(), rnd4(), rbit(), rbit(), e, "addr");
            fin = 1'b0;
            for (int k = 1; k <= MAX && !fin; k++) begin
                logic rdy;
                rdy = (k == lat);
                if (k == abort_k) begin
                    mem_ready = 1'b0;
                    #2;
                    apply_reset();
                    return;
                end
                e = base((op == 4'd5) ? 4'd6 : 4'd8);
                e.alusrc = 1'b1;
                if (op == 4'd5) e.memred = 1'b1;
                else            e.memwr  = 1'b1;
                if ((op == 4'd6 && rdy) || (!rdy && k == MAX)) e.done = 1'b1;
                step(rbit(), rnd4(), rdy, rbit(), e, (op == 4'd5) ? "mem_rd" : "mem_wr");
                if (!rdy && k == MAX) begin
                    m_err = 1'b1;
                    fin   = 1'b1;
                end
                if (rdy) begin
                    fin = 1'b1;
                    if (op == 4'd5) begin
                        e = base(4'd7); e.memtoreg = 1'b1; e.regwr = 1'b1; e.done = 1'b1;
                        step(rbit(), rnd4(), rbit(), rbit(), e, "wb_mem");
                    end
                end
            end
        end else if (op == 4'd7) begin
            e = base(4'd9); e.branch = 1'b1; e.aluop = 2'b01; e.pcwr = zr; e.done = 1'b1;
            step(rbit(), rnd4(), rbit(), zr, e, "br");
        end else begin
            e = base(4'd10); e.jump = 1'b1; e.pcwr = 1'b1; e.done = 1'b1;
            step(rbit(), rnd4(), rbit(), rbit(), e, "jmp");
        end
    endtask

    initial begin
        logic [3:0] op;
        reset_n     = 1'b0;
        instr_valid = 1'b0;
        code        = '0;
        zero        = 1'b0;
        mem_ready   = 1'b0;
        apply_reset();

        run_instr(4'd2, 0, 0, 1'b0, 0);
        run_instr(4'd5, 2, 4, 1'b0, 0);
        run_instr(4'd6, 1, 0, 1'b0, 0);
        // err is now set; a reset in the middle of a load must clear it and abort the load.
        run_instr(4'd5, 0, 0, 1'b0, 3);
        run_instr(4'd7, 0, 0, 1'b1, 0);
        run_instr(4'd7, 1, 0, 1'b0, 0);
        run_instr(4'd8, 0, 0, 1'b0, 0);
        run_instr(4'd6, 0, MAX, 1'b0, 0);
        run_instr(4'd5, 0, 1, 1'b0, 0);
        run_instr(4'd5, 0, MAX, 1'b0, 0);
`ifndef ILLEGAL_TRAP_EN
        run_instr(4'd15, 0, 0, 1'b0, 0);
`endif

        for (int n = 0; n < 150; n++) begin
`ifdef ILLEGAL_TRAP_EN
            op = 4'($urandom_range(0, 8));
`else
            op = rnd4();
`endif
            run_instr(op, $urandom_range(0, 3), $urandom_range(1, MAX + 3), rbit(),
                      ($urandom_range(0, 19) == 0) ? $urandom_range(1, 4) : 0);
        end

`ifdef ILLEGAL_TRAP_EN
        run_instr(4'd15, 0, 0, 1'b0, 0);
        apply_reset();
        run_instr(4'd1, 0, 0, 1'b0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
